inert_spi_seq: RTL and testbench

//  Transaction sequencer for the SPI monarch serving the inertial sensor.

---
 rtl/inert_spi_if.sv | 22 ++
 rtl/inert_spi_seq.sv | 198 +++++++++++++++++++
 tb/tb_inert_spi_seq.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inert_spi_if.sv
// SPI monarch command/response bus for the inertial sequencer.
// master: drives snd/cmd, samples done/resp; slave: the reverse.
interface inert_spi_if;
  logic        snd;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;

  modport master (
    output snd,
    output cmd,
    input  done,
    input  resp
  );

  modport slave (
    input  snd,
    input  cmd,
    output done,
    output resp
  );
endinterface

// File: rtl/inert_spi_seq.sv
// Inertial sensor SPI sequencer: power-up wait, three config writes,
// then a yaw L/H read per synchronized INT event.
// Ports: clk, rst_n (async, active-low), INT (async data-ready),
//   spi (master: snd/cmd out, done/resp in),
//   yaw_raw/vld (yaw result + one-clk strobe), cfg_done, err.
// Optional: INERT_SEQ_TIMEOUT_EN adds a done-wait timeout (sticky err).
module inert_spi_seq #(
  parameter int INIT_W      = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  inert_spi_if.master spi,
  output logic [15:0] yaw_raw,
  output logic        vld,
  output logic        cfg_done,
  output logic        err
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG_INT,
    CFG_GYRO,
    CFG_RND,
    IDLE,
    RD_YL,
    RD_YH
  } state_e;

  localparam logic [15:0] C_INT  = 16'h0D02;
  localparam logic [15:0] C_GYRO = 16'h1160;
  localparam logic [15:0] C_RND  = 16'h1440;
  localparam logic [15:0] C_YL   = 16'hA600;
  localparam logic [15:0] C_YH   = 16'hA700;

  state_e            state_q;
  logic [INIT_W-1:0] cnt_q;
  logic [INIT_W-1:0] cnt_d;
  logic              int_ff1_q;
  logic              int_ff2_q;
  logic              int_ff3_q;
  logic              evt_q;
  logic              pend_q;
  logic              done_q;
  logic              done_rise;
  logic [7:0]        yawl_q;
  logic              snd_q;
  logic [15:0]       cmd_q;
  logic [15:0]       yaw_q;
  logic              vld_q;
  logic              cfg_q;
  logic              tmo_hit;
  logic              unused_resp;

  assign cnt_d       = cnt_q + 1'b1;
  assign done_rise   = spi.done & ~done_q;
  assign unused_resp = ^spi.resp[15:8];

  assign spi.snd  = snd_q;
  assign spi.cmd  = cmd_q;
  assign yaw_raw  = yaw_q;
  assign vld      = vld_q;
  assign cfg_done = cfg_q;

`ifdef INERT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic          busy;

  assign busy = (state_q != PWR_WAIT) &&
                (state_q != IDLE);

  // The snd cycle itself counts as the first waited clock,
  // so the abort lands exactly TIMEOUT_CYC clocks after snd.
  assign tmo_hit = busy && !snd_q && !done_rise &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy || snd_q)
        tmo_q <= TW'(1);
      else
        tmo_q <= tmo_q + 1'b1;
      if (tmo_hit)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PWR_WAIT;
      cnt_q     <= '0;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      int_ff3_q <= 1'b0;
      evt_q     <= 1'b0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      yawl_q    <= '0;
      snd_q     <= 1'b0;
      cmd_q     <= '0;
      yaw_q     <= '0;
      vld_q     <= 1'b0;
      cfg_q     <= 1'b0;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      int_ff3_q <= int_ff2_q;
      evt_q     <= int_ff2_q & ~int_ff3_q;
      done_q    <= spi.done;
      snd_q     <= 1'b0;
      vld_q     <= 1'b0;

      // Events before configuration completes are dropped.
      if (evt_q && cfg_q && state_q != IDLE)
        pend_q <= 1'b1;

      unique case (state_q)
        PWR_WAIT: begin
          cnt_q <= cnt_d;
          if (&cnt_d) begin
            cnt_q   <= '0;
            state_q <= CFG_INT;
            snd_q   <= 1'b1;
            cmd_q   <= C_INT;
          end
        end
        CFG_INT: begin
          if (tmo_hit) begin
            state_q <= PWR_WAIT;
          end else if (done_rise) begin
            state_q <= CFG_GYRO;
            snd_q   <= 1'b1;
            cmd_q   <= C_GYRO;
          end
        end
        CFG_GYRO: begin
          if (tmo_hit) begin
            state_q <= PWR_WAIT;
          end else if (done_rise) begin
            state_q <= CFG_RND;
            snd_q   <= 1'b1;
            cmd_q   <= C_RND;
          end
        end
        CFG_RND: begin
          if (tmo_hit) begin
            state_q <= PWR_WAIT;
          end else if (done_rise) begin
            state_q <= IDLE;
            cfg_q   <= 1'b1;
          end
        end
        IDLE: begin
          if (evt_q || pend_q) begin
            state_q <= RD_YL;
            snd_q   <= 1'b1;
            cmd_q   <= C_YL;
            pend_q  <= 1'b0;
          end
        end
        RD_YL: begin
          if (tmo_hit) begin
            state_q <= IDLE;
          end else if (done_rise) begin
            yawl_q  <= spi.resp[7:0];
            state_q <= RD_YH;
            snd_q   <= 1'b1;
            cmd_q   <= C_YH;
          end
        end
        RD_YH: begin
          if (tmo_hit) begin
            state_q <= IDLE;
          end else if (done_rise) begin
            yaw_q   <= {spi.resp[7:0], yawl_q};
            vld_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_spi_seq.sv
// Bench for inert_spi_seq: SPI monarch model, transaction-level
// scoreboard checked every cycle, plus directed scenarios.
module tb_inert_spi_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        INT   = 1'b0;
  logic [15:0] yaw_raw;
  logic        vld;
  logic        cfg_done;
  logic        err;

  inert_spi_if spi ();

  inert_spi_seq #(
    .INIT_W      (4),
    .TIMEOUT_CYC (1023)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .INT      (INT),
    .spi      (spi),
    .yaw_raw  (yaw_raw),
    .vld      (vld),
    .cfg_done (cfg_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // ---------------- SPI monarch model ----------------
  int          lat      = 40;
  bit          withhold = 1'b0;
  logic [7:0]  lo_b, hi_b, lo_got;
  logic [15:0] scmd;
  logic [15:0] yaw_next;
  int          cfg_seen = 0;
  int          cfg_cyc  = -1;
  int          hi_cyc   = -1;
  bit          abort;

  initial begin
    spi.done = 1'b0;
    spi.resp = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        spi.done = 1'b0;
        cfg_seen = 0;
        cfg_cyc  = -1;
        hi_cyc   = -1;
        continue;
      end
      if (spi.snd) begin
        scmd     = spi.cmd;
        spi.done = 1'b0;
        abort    = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            abort = 1'b1;
            break;
          end
        end
        if (abort) begin
          spi.done = 1'b0;
          cfg_seen = 0;
          cfg_cyc  = -1;
          hi_cyc   = -1;
          continue;
        end
        if (withhold) continue;
        if (scmd == 16'hA600) begin
          spi.resp = {8'hC3, lo_b};
          lo_got   = lo_b;
        end else if (scmd == 16'hA700) begin
          spi.resp = {8'h5A, hi_b};
          yaw_next = {hi_b, lo_got};
          hi_cyc   = cyc;
        end else begin
          spi.resp = 16'hFFFF;
          cfg_seen++;
          if (cfg_seen == 3) cfg_cyc = cyc;
        end
        spi.done = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [15:0] cfg_tbl [3] = '{16'h0D02, 16'h1160, 16'h1440};
  int          m_cfg   = 0;
  bit          m_rd    = 1'b0;
  logic [15:0] yaw_cur = 16'h0000;
  logic [15:0] exp_cmd;
  bit          vld_exp;
  bit          cfg_exp;
  int          n_snd   = 0;
  int          n_vld   = 0;
  bit          err_ok  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_cfg   = 0;
        m_rd    = 1'b0;
        yaw_cur = 16'h0000;
        chk("rst_outputs",
            {spi.snd, vld, cfg_done, err, spi.cmd, yaw_raw}, 64'd0);
        continue;
      end
      if (spi.snd) begin
        n_snd++;
        if (m_cfg < 3) begin
          exp_cmd = cfg_tbl[m_cfg];
          m_cfg++;
        end else begin
          exp_cmd = m_rd ? 16'hA700 : 16'hA600;
          m_rd    = !m_rd;
        end
        chk("cmd_seq", spi.cmd, exp_cmd);
      end
      if (vld) n_vld++;
      vld_exp = (hi_cyc >= 0) && (cyc == hi_cyc + 1);
      if (vld_exp) yaw_cur = yaw_next;
      chk("vld", vld, vld_exp);
      chk("yaw_raw", yaw_raw, yaw_cur);
      cfg_exp = (cfg_cyc >= 0) && (cyc > cfg_cyc);
      chk("cfg_done", cfg_done, cfg_exp);
      if (!err_ok) chk("err_low", err, 1'b0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_snd(input string nm, input int bound,
                          output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!spi.snd && k < bound);
    if (!spi.snd) expire(nm);
  endtask

  task automatic wait_cfg(input int bound);
    int t = 0;
    while (!cfg_done && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_done) expire("cfg_wait");
  endtask

  task automatic wait_vld(input string nm, input int bound);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!vld && t < bound);
    if (!vld) expire(nm);
  endtask

  task automatic int_pulse(input int hi_clks);
    @(negedge clk);
    INT = 1'b1;
    repeat (hi_clks) @(negedge clk);
    INT = 1'b0;
  endtask

  // Release reset at a negedge and confirm the power-up wait.
  task automatic boot(input string tag);
    int k;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      INT = (k == 5 || k == 6);
    end while (!spi.snd && k < 100);
    INT = 1'b0;
    chk({tag, "_first_snd_clk"}, k, 15);
    chk({tag, "_first_cmd"}, spi.cmd, 16'h0D02);
  endtask

  int k;
  int t0;
  int nv;

  initial begin
    lo_b = 8'h34;
    hi_b = 8'h12;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    boot("boot");

    // INT during configuration must be dropped.
    repeat (50) @(negedge clk);
    int_pulse(3);
    wait_cfg(400);
    repeat (30) @(negedge clk);
    chk("precfg_snd", n_snd, 3);
    chk("precfg_vld", n_vld, 0);
    chk("precfg_yaw", yaw_raw, 16'h0000);

    // Single read.
    @(negedge clk);
    INT = 1'b1;
    wait_snd("rd1_snd", 20, k);
    INT = 1'b0;
    chk("int_to_snd", k, 4);
    chk("rd1_cmd", spi.cmd, 16'hA600);
    wait_vld("rd1_vld", 200);
    chk("yaw_1234", yaw_raw, 16'h1234);
    repeat (20) @(negedge clk);
    chk("rd1_vld_cnt", n_vld, 1);
    chk("rd1_snd_cnt", n_snd, 5);

    // Three INTs while busy collapse into one extra read.
    lo_b = 8'h78;
    hi_b = 8'h56;
    @(negedge clk);
    INT = 1'b1;
    wait_snd("rd2_snd", 20, k);
    INT = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (5) @(negedge clk);
      INT = 1'b1;
      repeat (3) @(negedge clk);
      INT = 1'b0;
    end
    repeat (300) @(negedge clk);
    chk("collapse_vld", n_vld, 3);
    chk("collapse_snd", n_snd, 9);
    chk("yaw_5678", yaw_raw, 16'h5678);

    // Reset while in RD_YH.
    lo_b = 8'h9A;
    hi_b = 8'hBC;
    @(negedge clk);
    INT = 1'b1;
    wait_snd("rd3_yl", 20, k);
    INT = 1'b0;
    wait_snd("rd3_yh", 100, k);
    chk("rd3_yh_cmd", spi.cmd, 16'hA700);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_yaw", yaw_raw, 16'h0000);
    chk("midrst_cfg", cfg_done, 1'b0);
    chk("midrst_vld_cnt", n_vld, 3);
    boot("reboot");
    wait_cfg(400);
    repeat (5) @(negedge clk);
    int_pulse(3);
    wait_vld("rd4_vld", 200);
    chk("yaw_bc9a", yaw_raw, 16'hBC9A);

`ifdef INERT_SEQ_TIMEOUT_EN
    // Withheld done in RD_YL: abort after 1023 clks.
    repeat (10) @(negedge clk);
    err_ok   = 1'b1;
    withhold = 1'b1;
    nv       = n_vld;
    @(negedge clk);
    INT = 1'b1;
    wait_snd("tmo_snd", 20, k);
    INT = 1'b0;
    t0 = cyc;
    k  = 0;
    while (!err && k < 1100) begin
      @(negedge clk);
      k++;
    end
    if (!err) expire("tmo_err");
    chk("tmo_clks", cyc - t0, 1023);
    m_rd     = 1'b0;
    withhold = 1'b0;
    repeat (5) @(negedge clk);
    chk("tmo_no_vld", n_vld, nv);
    lo_b = 8'hCD;
    hi_b = 8'hAB;
    int_pulse(3);
    wait_vld("tmo_next_vld", 200);
    chk("yaw_abcd", yaw_raw, 16'hABCD);
    chk("err_sticky", err, 1'b1);
`else
    chk("err_absent", err, 1'b0);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
